// File: rtl/register_file.sv
// Purpose : 2**ADDR_W x DATA_W register file, three async read ports, one write port
// Latency : reads combinational; write lands on the rising clk edge after regWrite=1
// Backpressure: none. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic              select,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd1,
    input  logic [ADDR_W-1:0] rd2,
    output logic [DATA_W-1:0] regRs,
    output logic [DATA_W-1:0] regRt,
    output logic [DATA_W-1:0] regRd
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [ADDR_W-1:0] w_dest;
    logic              w_wr_en;

    // The destination mux feeds both the write port and the regRd read port.
    assign w_dest = select ? rd1 : rd2;

`ifdef REGFILE_ZERO_REG_EN
    // Register 0 is a constant: drop writes to it and force its reads to zero.
    assign w_wr_en = regWrite && (w_dest != '0);
    assign regRs   = (rs     == '0) ? '0 : r_regs[rs];
    assign regRt   = (rt     == '0) ? '0 : r_regs[rt];
    assign regRd   = (w_dest == '0) ? '0 : r_regs[w_dest];
`else
    assign w_wr_en = regWrite;
    assign regRs   = r_regs[rs];
    assign regRt   = r_regs[rt];
    assign regRd   = r_regs[w_dest];
`endif

    // Storage: reset clears every entry immediately; otherwise one entry per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_dest] <= WriteData;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes hand-computed read results
// into a queue; a negedge monitor pops and compares whenever a check is strobed.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regWrite = 1'b0;
    logic        select = 1'b0;
    logic [15:0] WriteData = '0;
    logic [3:0]  rs = '0, rt = '0, rd1 = '0, rd2 = '0;
    logic [15:0] regRs, regRt, regRd;

    logic        chk_vld = 1'b0;

    typedef struct {
        string       name;
        logic [15:0] e_rs;
        logic [15:0] e_rt;
        logic [15:0] e_rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [15:0] REG0_AFTER_FFFF = 16'h0000;
`else
    localparam logic [15:0] REG0_AFTER_FFFF = 16'hFFFF;
`endif

    register_file #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .regWrite (regWrite),
        .select   (select),
        .WriteData(WriteData),
        .rs       (rs),
        .rt       (rt),
        .rd1      (rd1),
        .rd2      (rd2),
        .regRs    (regRs),
        .regRt    (regRt),
        .regRd    (regRd)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string port, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s %s: got %h expected %h", nm, port, got, want);
    endtask

    // Monitor: mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL monitor: output strobe with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "regRs", regRs, e.e_rs);
                cmp(e.name, "regRt", regRt, e.e_rt);
                cmp(e.name, "regRd", regRd, e.e_rd);
            end
        end
    end

    // Advance to just after the next rising edge and drive a full input vector.
    task automatic step(input logic rst_v, input logic we, input logic sel,
                        input logic [3:0] d1, input logic [3:0] d2, input logic [15:0] wd,
                        input logic [3:0] a_rs, input logic [3:0] a_rt);
        @(posedge clk);
        #1;
        chk_vld   = 1'b0;
        reset     = rst_v;
        regWrite  = we;
        select    = sel;
        rd1       = d1;
        rd2       = d2;
        WriteData = wd;
        rs        = a_rs;
        rt        = a_rt;
    endtask

    task automatic expect_rd(input string nm, input logic [15:0] e_rs,
                             input logic [15:0] e_rt, input logic [15:0] e_rd);
        exp_t e;
        e.name = nm; e.e_rs = e_rs; e.e_rt = e_rt; e.e_rd = e_rd;
        exp_q.push_back(e);
        chk_vld = 1'b1;
    endtask

    task automatic wr(input logic sel, input logic [3:0] d1, input logic [3:0] d2, input logic [15:0] wd);
        step(1'b0, 1'b1, sel, d1, d2, wd, 4'd0, 4'd0);
    endtask

    task automatic rdchk(input string nm, input logic [3:0] a_rs, input logic [3:0] a_rt,
                         input logic sel, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [15:0] e_rs, input logic [15:0] e_rt, input logic [15:0] e_rd);
        step(1'b0, 1'b0, sel, d1, d2, 16'h0, a_rs, a_rt);
        expect_rd(nm, e_rs, e_rt, e_rd);
    endtask

    initial begin
        // Reset held, with a concurrent write that must be ignored.
        step(1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 16'hAAAA, 4'd3, 4'd7);
        expect_rd("reset_read", 16'h0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 16'h0, 4'd3, 4'd12);
        expect_rd("reset_beats_write", 16'h0, 16'h0, 16'h0);

        // Odd registers through rd1 (rd2 ignored), even through rd2 (rd1 ignored).
        for (int n = 1; n <= 9; n += 2) wr(1'b1, 4'(n), 4'd15, 16'(n));
        for (int n = 2; n <= 10; n += 2) wr(1'b0, 4'd11, 4'(n), 16'(n));

        rdchk("sel1_rd1",   4'd1,  4'd2,  1'b1, 4'd3, 4'd0,  16'd1,  16'd2, 16'd3);
        rdchk("sel0_rd2",   4'd4,  4'd5,  1'b0, 4'd0, 4'd6,  16'd4,  16'd5, 16'd6);
        rdchk("sel1_hi",    4'd7,  4'd8,  1'b1, 4'd9, 4'd0,  16'd7,  16'd8, 16'd9);
        rdchk("ignored_rd", 4'd10, 4'd11, 1'b0, 4'd0, 4'd15, 16'd10, 16'd0, 16'd0);

        // regWrite=0 with changing WriteData: nothing moves.
        step(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 16'h1234, 4'd0, 4'd2);
        expect_rd("no_write_a", 16'd0, 16'd2, 16'd1);
        step(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 16'hBEEF, 4'd0, 4'd2);
        expect_rd("no_write_b", 16'd0, 16'd2, 16'd1);
        rdchk("no_write_c", 4'd3, 4'd1, 1'b0, 4'd0, 4'd3, 16'd3, 16'd1, 16'd3);

        // No bypass: old value visible during the write cycle, new value after.
        step(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 16'h55AA, 4'd5, 4'd5);
        expect_rd("bypass_old", 16'd5, 16'd5, 16'd5);
        rdchk("bypass_new", 4'd5, 4'd4, 1'b1, 4'd5, 4'd0, 16'h55AA, 16'd4, 16'h55AA);

        // Register 0 behaviour depends on the build.
        wr(1'b0, 4'd7, 4'd0, 16'hFFFF);
        rdchk("reg0", 4'd0, 4'd0, 1'b0, 4'd7, 4'd0, REG0_AFTER_FFFF, REG0_AFTER_FFFF, REG0_AFTER_FFFF);

        // Top address, full-width pattern.
        wr(1'b1, 4'd15, 4'd0, 16'h8001);
        rdchk("reg15", 4'd15, 4'd7, 1'b1, 4'd15, 4'd1, 16'h8001, 16'd7, 16'h8001);

        // Reset between edges after a write clears everything before the next edge.
        wr(1'b1, 4'd14, 4'd0, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 4'd15, 4'd0, 16'h0, 4'd14, 4'd1);
        expect_rd("mid_reset", 16'h0, 16'h0, 16'h0);
        rdchk("after_reset", 4'd1, 4'd2, 1'b1, 4'd9, 4'd0, 16'h0, 16'h0, 16'h0);

        // First write after reset release lands on the first enabled edge.
        wr(1'b1, 4'd2, 4'd0, 16'h0022);
        rdchk("first_write", 4'd2, 4'd14, 1'b0, 4'd0, 4'd2, 16'h0022, 16'h0, 16'h0022);

        // Drain: let the monitor consume the last strobe, then confirm the queue emptied.
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 4'd0, 4'd0);
        @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 4, meaning address width; register count = 2**ADDR_W (16).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port regWrite  input  1  write enable.
REQ-006 The block SHALL have port select  input  1  destination select: 1 = rd1, 0 = rd2.
REQ-007 The block SHALL have port WriteData  input  DATA_W  write data.
REQ-008 The block SHALL have port rs  input  ADDR_W  read address for regRs.
REQ-009 The block SHALL have port rt  input  ADDR_W  read address for regRt.
REQ-010 The block SHALL have port rd1  input  ADDR_W  destination address 1.
REQ-011 The block SHALL have port rd2  input  ADDR_W  destination address 2.
REQ-012 The block SHALL have port regRs  output  DATA_W  contents of register rs.
REQ-013 The block SHALL have port regRt  output  DATA_W  contents of register rt.
REQ-014 The block SHALL have port regRd  output  DATA_W  contents of the selected destination register.
REQ-015 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-016 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-017 Destination address SHALL be dest = select ? rd1 : rd2, combinational.
REQ-018 On rising clk with reset=0 and regWrite=1, register[dest] SHALL load WriteData; latency one edge.
REQ-019 With regWrite=0 no register SHALL change.
REQ-020 Reads SHALL be combinational and asynchronous: regRs = register[rs], regRt = register[rt], regRd = register[dest].
REQ-021 No write-to-read bypass: a read of the address being written SHALL return the old value before the edge and the new value after it.
REQ-022 Only one register SHALL be written per edge; the non-selected rd address SHALL have no effect on writes.
REQ-023 X/Z on select while regWrite=1 SHALL NOT be a supported condition; the bench SHALL drive select whenever regWrite=1.

Reset
REQ-024 reset=1 SHALL immediately clear all registers to 0 regardless of clk; regRs/regRt/regRd SHALL read 0 for any address.
REQ-025 reset SHALL take priority over any write in the same cycle; reset asserted mid-sequence SHALL discard all prior writes.
REQ-026 After reset deassertion, the first write SHALL occur on the first rising clk with regWrite=1.

Configuration
REQ-027 Macro REGFILE_ZERO_REG_EN SHALL, when defined, make register 0 hardwired to 0: writes to address 0 ignored, reads of address 0 return 0 on all three outputs.
REQ-028 Without REGFILE_ZERO_REG_EN, register 0 SHALL be an ordinary writable register.

Verification
REQ-029 Reset: assert reset, any rs/rt/rd1 -> regRs=regRt=regRd=0.
REQ-030 select=1, regWrite=1, five edges writing rd1=1,3,5,7,9 with WriteData=1,3,5,7,9 -> register[n] reads n.
REQ-031 select=0, regWrite=1, five edges writing rd2=2,4,6,8,10 with WriteData=2,4,6,8,10 -> register[n] reads n; rd1 value ignored.
REQ-032 regWrite=0, select=1, rs=0, rt=2, rd1=1, rd2=3, WriteData changing -> regRs=0, regRt=2, regRd=1, no register changes.
REQ-033 Write 16'hFFFF to register 0 -> reads 16'hFFFF without macro, 0 with REGFILE_ZERO_REG_EN.
REQ-034 Assert reset between clock edges after writes -> all outputs 0 before the next clk edge.
